hrange_vec: RTL and testbench

- Parametrised successor to the scalar range generator.
- Emits the Python sequence range(base, limit, step) as LANES values per ready/valid beat, with a lane mask for the partial final beat.
- Supports positive and negative steps and configurable width.
- Sits behind the func_call caller FSMs that consume generator outputs.

---
 rtl/hrange_pkg.sv | 26 ++
 rtl/hrange_vec_if.sv | 15 +
 rtl/hrange_lanes.sv | 45 ++++
 rtl/hrange_vec.sv | 170 +++++++++++++++++
 tb/tb_hrange_vec.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hrange_pkg.sv
// Shared types and helpers for the vector range generator.
package hrange_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Widest internal candidate supported; callers sign-extend into this type.
  localparam int unsigned MAXW = 128;
  typedef logic signed [MAXW-1:0] wide_t;

  // Candidate width: headroom for i + LANES*step without wrap.
  function automatic int unsigned ext_width(input int unsigned w, input int unsigned lanes);
    return w + $clog2(lanes + 1) + 1;
  endfunction

  // Limit is itself inside the WIDTH range, so a value that passes this
  // compare can never lie outside the WIDTH signed range.
  function automatic logic in_range(input wide_t v, input wide_t lim, input wide_t stp);
    if (stp == '0)          return 1'b0;
    else if (stp[MAXW-1])   return v > lim;
    else                    return v < lim;
  endfunction

endpackage

// File: rtl/hrange_vec_if.sv
// Beat-side handshake bundle of the vector range generator.
interface hrange_vec_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 4
);
  logic                   _ready;
  logic                   _valid;
  logic                   _done;
  logic [LANES*WIDTH-1:0] _0;
  logic [LANES-1:0]       _mask;
  logic                   _last;

  modport master (input _ready, output _valid, _done, _0, _mask, _last);
  modport slave  (output _ready, input _valid, _done, _0, _mask, _last);
endinterface

// File: rtl/hrange_lanes.sv
// Combinational lane evaluator: LANES candidates from i, lane mask, last flag
// and the base of the following beat.
module hrange_lanes
  import hrange_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 4
) (
  input  logic signed [WIDTH-1:0] i_i,
  input  logic signed [WIDTH-1:0] step_i,
  input  logic signed [WIDTH-1:0] limit_i,
  output logic [LANES*WIDTH-1:0]  vals_o,
  output logic [LANES-1:0]        mask_o,
  output logic                    last_o,
  output logic [WIDTH-1:0]        next_o
);

  localparam int unsigned EW = ext_width(WIDTH, LANES);

  logic signed [EW-1:0] acc;
  logic signed [EW-1:0] step_x;
  wide_t                lim_w;
  wide_t                stp_w;
  logic                 lane_ok;

  // Walk the lanes by repeated addition in the extended width.
  always_comb begin
    vals_o  = '0;
    mask_o  = '0;
    lane_ok = 1'b0;
    step_x  = EW'(step_i);
    lim_w   = MAXW'(limit_i);
    stp_w   = MAXW'(step_i);
    acc     = EW'(i_i);
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_ok   = in_range(MAXW'(acc), lim_w, stp_w);
      mask_o[k] = lane_ok;
      if (lane_ok) vals_o[k*WIDTH +: WIDTH] = acc[WIDTH-1:0];
      acc = acc + step_x;
    end
    last_o = ~(&mask_o) | ~in_range(MAXW'(acc), lim_w, stp_w);
    next_o = acc[WIDTH-1:0];
  end

endmodule

// File: rtl/hrange_vec.sv
// Vector range(base, limit, step) generator, LANES values per ready/valid beat.
// Optional HRANGE_VEC_COUNT_EN adds a saturating transferred-value counter.
module hrange_vec
  import hrange_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 4
) (
  input  logic                    _clock,
  input  logic                    _reset_n,
  input  logic                    _start,
  input  logic signed [WIDTH-1:0] base,
  input  logic signed [WIDTH-1:0] limit,
  input  logic signed [WIDTH-1:0] step,
  hrange_vec_if.master            out_if
`ifdef HRANGE_VEC_COUNT_EN
  ,
  output logic [WIDTH-1:0]        _count
`endif
);

  state_t                 state_q, state_d;
  logic                   valid_q, valid_d;
  logic                   done_q,  done_d;
  logic                   last_q,  last_d;
  logic [LANES-1:0]       mask_q,  mask_d;
  logic [LANES*WIDTH-1:0] data_q,  data_d;
  logic [WIDTH-1:0]       nxt_q,   nxt_d;
  logic [WIDTH-1:0]       step_q,  step_d;
  logic [WIDTH-1:0]       limit_q, limit_d;

  logic [LANES*WIDTH-1:0] lane_vals;
  logic [LANES-1:0]       lane_mask;
  logic                   lane_last;
  logic [WIDTH-1:0]       lane_next;
  logic signed [WIDTH-1:0] lane_i, lane_step, lane_limit;

`ifdef HRANGE_VEC_COUNT_EN
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH:0]   count_sum;
`endif

  // One evaluator serves both a fresh start and the advance to the next beat.
  assign lane_i     = _start ? base  : $signed(nxt_q);
  assign lane_step  = _start ? step  : $signed(step_q);
  assign lane_limit = _start ? limit : $signed(limit_q);

  hrange_lanes #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_lanes (
    .i_i     (lane_i),
    .step_i  (lane_step),
    .limit_i (lane_limit),
    .vals_o  (lane_vals),
    .mask_o  (lane_mask),
    .last_o  (lane_last),
    .next_o  (lane_next)
  );

  always_ff @(posedge _clock) begin
    if (!_reset_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      done_q  <= 1'b1;
      last_q  <= 1'b0;
      mask_q  <= '0;
      data_q  <= '0;
      nxt_q   <= '0;
      step_q  <= '0;
      limit_q <= '0;
`ifdef HRANGE_VEC_COUNT_EN
      count_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      last_q  <= last_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      nxt_q   <= nxt_d;
      step_q  <= step_d;
      limit_q <= limit_d;
`ifdef HRANGE_VEC_COUNT_EN
      count_q <= count_d;
`endif
    end
  end

`ifdef HRANGE_VEC_COUNT_EN
  assign count_sum = {1'b0, count_q} + (WIDTH+1)'($countones(mask_q));
`endif

  // Next-state: start wins over any pending beat; a transfer either ends or advances.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    done_d  = done_q;
    last_d  = last_q;
    mask_d  = mask_q;
    data_d  = data_q;
    nxt_d   = nxt_q;
    step_d  = step_q;
    limit_d = limit_q;
`ifdef HRANGE_VEC_COUNT_EN
    count_d = count_q;
`endif

    if (_start) begin
      step_d  = step;
      limit_d = limit;
`ifdef HRANGE_VEC_COUNT_EN
      count_d = '0;
`endif
      if (lane_mask[0]) begin
        state_d = RUN;
        valid_d = 1'b1;
        done_d  = 1'b0;
        data_d  = lane_vals;
        mask_d  = lane_mask;
        last_d  = lane_last;
        nxt_d   = lane_next;
      end else begin
        state_d = IDLE;
        valid_d = 1'b0;
        done_d  = 1'b1;
        data_d  = '0;
        mask_d  = '0;
        last_d  = 1'b0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (out_if._ready) begin
`ifdef HRANGE_VEC_COUNT_EN
            count_d = count_sum[WIDTH] ? '1 : count_sum[WIDTH-1:0];
`endif
            if (last_q) begin
              state_d = IDLE;
              valid_d = 1'b0;
              done_d  = 1'b1;
              data_d  = '0;
              mask_d  = '0;
              last_d  = 1'b0;
            end else begin
              valid_d = 1'b1;
              done_d  = 1'b0;
              data_d  = lane_vals;
              mask_d  = lane_mask;
              last_d  = lane_last;
              nxt_d   = lane_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_if._valid = valid_q;
  assign out_if._done  = done_q;
  assign out_if._0     = data_q;
  assign out_if._mask  = mask_q;
  assign out_if._last  = last_q;
`ifdef HRANGE_VEC_COUNT_EN
  assign _count = count_q;
`endif

endmodule

// File: tb/tb_hrange_vec.sv
// Randomised bench for hrange_vec: a 32-bit/4-lane and an 8-bit/3-lane DUT
// run in lockstep against a sequence-level reference model.
module tb_hrange_vec;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        rdy;
  logic [31:0] base_s, limit_s, step_s;

  hrange_vec_if #(.WIDTH(32), .LANES(4)) bus_a ();
  hrange_vec_if #(.WIDTH(8),  .LANES(3)) bus_b ();

  assign bus_a._ready = rdy;
  assign bus_b._ready = rdy;

`ifdef HRANGE_VEC_COUNT_EN
  logic [31:0] cnt_a;
  logic [7:0]  cnt_b;
`endif

  hrange_vec #(.WIDTH(32), .LANES(4)) dut_a (
    ._clock   (clk),
    ._reset_n (rst_n),
    ._start   (start),
    .base     (base_s),
    .limit    (limit_s),
    .step     (step_s),
    .out_if   (bus_a)
`ifdef HRANGE_VEC_COUNT_EN
    , ._count (cnt_a)
`endif
  );

  hrange_vec #(.WIDTH(8), .LANES(3)) dut_b (
    ._clock   (clk),
    ._reset_n (rst_n),
    ._start   (start),
    .base     (base_s[7:0]),
    .limit    (limit_s[7:0]),
    .step     (step_s[7:0]),
    .out_if   (bus_b)
`ifdef HRANGE_VEC_COUNT_EN
    , ._count (cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the full Python range as a list, consumed LANES at a time.
  longint seqv [2][512];
  int     seq_n [2];
  int     seq_h [2];
  longint cnt_m [2];

  function automatic int lanes_of(input int m);
    return (m == 0) ? 4 : 3;
  endfunction

  function automatic int width_of(input int m);
    return (m == 0) ? 32 : 8;
  endfunction

  function automatic longint sx(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  task automatic gen(input int m, input longint b, input longint l, input longint s);
    longint v;
    seq_n[m] = 0;
    seq_h[m] = 0;
    v = b;
    if (s != 0) begin
      while (((s > 0) ? (v < l) : (v > l)) && seq_n[m] < 512) begin
        seqv[m][seq_n[m]] = v;
        seq_n[m]++;
        v = v + s;
      end
    end
  endtask

  task automatic model_step(input int m, input logic st, input longint b, input longint l,
                            input longint s, input logic r, input logic rn);
    int w, ln, k;
    longint mx;
    w  = width_of(m);
    ln = lanes_of(m);
    mx = (longint'(1) <<< w) - 1;
    if (!rn) begin
      seq_n[m] = 0;
      seq_h[m] = 0;
      cnt_m[m] = 0;
    end else if (st) begin
      gen(m, sx(b, w), sx(l, w), sx(s, w));
      cnt_m[m] = 0;
    end else if (seq_h[m] < seq_n[m] && r) begin
      k = seq_n[m] - seq_h[m];
      if (k > ln) k = ln;
      cnt_m[m] = cnt_m[m] + k;
      if (cnt_m[m] > mx) cnt_m[m] = mx;
      seq_h[m] = seq_h[m] + ln;
    end
  endtask

  task automatic check_outputs(input int m);
    int w, ln, h, n, k;
    logic [127:0] exp_d;
    logic [127:0] obs_d;
    logic         pend;
    longint       tv;
    w  = width_of(m);
    ln = lanes_of(m);
    h  = seq_h[m];
    n  = seq_n[m];
    pend  = (h < n);
    exp_d = '0;
    k = 0;
    if (pend) begin
      for (int j = 0; j < ln; j++) begin
        if (h + j < n) begin
          tv    = seqv[m][h + j];
          exp_d = exp_d | ((128'(tv) & ((128'(1) << w) - 128'(1))) << (j * w));
          k++;
        end
      end
    end
    if (m == 0) begin
      obs_d = 128'(bus_a._0);
      check("a_valid", 128'(bus_a._valid), 128'(pend));
      check("a_done",  128'(bus_a._done),  128'(!pend));
      check("a_mask",  128'(bus_a._mask),  (128'(1) << k) - 128'(1));
      check("a_last",  128'(bus_a._last),  128'(pend && (h + ln >= n)));
      check("a_data",  obs_d, exp_d);
`ifdef HRANGE_VEC_COUNT_EN
      check("a_count", 128'(cnt_a), 128'(cnt_m[0]));
`endif
    end else begin
      obs_d = 128'(bus_b._0);
      check("b_valid", 128'(bus_b._valid), 128'(pend));
      check("b_done",  128'(bus_b._done),  128'(!pend));
      check("b_mask",  128'(bus_b._mask),  (128'(1) << k) - 128'(1));
      check("b_last",  128'(bus_b._last),  128'(pend && (h + ln >= n)));
      check("b_data",  obs_d, exp_d);
`ifdef HRANGE_VEC_COUNT_EN
      check("b_count", 128'(cnt_b), 128'(cnt_m[1]));
`endif
    end
  endtask

  task automatic cycle(input logic st, input longint b, input longint l, input longint s,
                       input logic r, input logic rn);
    start   = st;
    base_s  = b[31:0];
    limit_s = l[31:0];
    step_s  = s[31:0];
    rdy     = r;
    rst_n   = rn;
    @(posedge clk);
    model_step(0, st, b, l, s, r, rn);
    model_step(1, st, b, l, s, r, rn);
    @(negedge clk);
    start = 1'b0;
    check_outputs(0);
    check_outputs(1);
  endtask

  function automatic logic idle_both();
    return (seq_h[0] >= seq_n[0]) && (seq_h[1] >= seq_n[1]);
  endfunction

  task automatic pick(output longint b, output longint l, output longint s);
    longint maxi, mini;
    int mode;
    maxi = 64'sd2147483647;
    mini = -64'sd2147483648;
    mode = $urandom_range(0, 3);
    if (mode == 1) begin
      b = maxi - longint'($urandom_range(0, 60));
      l = maxi - longint'($urandom_range(0, 2));
      s = longint'($urandom_range(1, 9));
    end else if (mode == 2) begin
      b = mini + longint'($urandom_range(0, 60));
      l = mini + longint'($urandom_range(0, 2));
      s = -longint'($urandom_range(1, 9));
    end else begin
      b = longint'($urandom_range(0, 100)) - 50;
      l = longint'($urandom_range(0, 100)) - 50;
      s = longint'($urandom_range(0, 14)) - 7;
    end
  endtask

  initial begin
    longint b, l, s;
    start = 1'b0; rdy = 1'b0; rst_n = 1'b0;
    base_s = '0; limit_s = '0; step_s = '0;
    seq_n = '{0, 0}; seq_h = '{0, 0}; cnt_m = '{0, 0};
    @(negedge clk);

    cycle(0, 0, 0, 0, 1, 0);
    cycle(1, 0, 10, 2, 1, 0);

    cycle(1, 0, 10, 2, 1, 1);
    check("tp1_beat0", 128'(bus_a._0), 128'({32'd6, 32'd4, 32'd2, 32'd0}));
    check("tp1_mask0", 128'(bus_a._mask), 128'(4'b1111));
    cycle(0, 0, 0, 0, 1, 1);
    check("tp1_beat1", 128'(bus_a._0), 128'({32'd0, 32'd0, 32'd0, 32'd8}));
    check("tp1_last1", 128'(bus_a._last), 128'(1'b1));
    for (int c = 0; c < 4; c++) cycle(0, 0, 0, 0, 1, 1);

    cycle(1, 10, 0, -3, 1, 1);
    check("tp2_beat", 128'(bus_a._0), 128'({32'd1, 32'd4, 32'd7, 32'd10}));
    for (int c = 0; c < 3; c++) cycle(0, 0, 0, 0, 1, 1);

    cycle(1, 5, 5, 1, 1, 1);
    cycle(0, 0, 0, 0, 1, 1);
    cycle(1, 0, 10, 0, 1, 1);
    cycle(0, 0, 0, 0, 1, 1);

    cycle(1, 120, 127, 4, 1, 1);
    check("tp4_w8", 128'(bus_b._0), 128'({8'd0, 8'd124, 8'd120}));
    check("tp4_w8m", 128'(bus_b._mask), 128'(3'b011));
    for (int c = 0; c < 3; c++) cycle(0, 0, 0, 0, 1, 1);

    cycle(1, 0, 40, 1, 0, 1);
    for (int c = 0; c < 3; c++) cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 0, 4, 1, 0, 1);
    check("tp5_drop", 128'(bus_a._0), 128'({32'd3, 32'd2, 32'd1, 32'd0}));
    for (int c = 0; c < 4; c++) cycle(0, 0, 0, 0, 1, 1);

    cycle(1, 0, 40, 1, 1, 1);
    cycle(0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 1);

    for (int t = 0; t < 60; t++) begin
      pick(b, l, s);
      cycle(1, b, l, s, 1'($urandom_range(0, 1)), 1);
      for (int c = 0; c < 120 && !idle_both(); c++) begin
        if ($urandom_range(0, 39) == 0) begin
          pick(b, l, s);
          cycle(1, b, l, s, 1'($urandom_range(0, 1)), 1);
        end else if ($urandom_range(0, 79) == 0) begin
          cycle(0, 0, 0, 0, 1, 0);
        end else begin
          cycle(0, 0, 0, 0, 1'($urandom_range(0, 3) != 0), 1);
        end
      end
      cycle(0, 0, 0, 0, 1, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
